// File: rtl/core_ctrl_if.sv
// Host/core-side signal bundle for the core sequencing controller.
// The controller sits on the slave modport; the host or bench drives the master side.
interface core_ctrl_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        ofifo_valid;
  logic [18:0] inst;
  logic        busy;
  logic        done;

  modport master (
    output start, in_valid, ofifo_valid,
    input  in_ready, inst, busy, done
  );

  modport slave (
    input  start, in_valid, ofifo_valid,
    output in_ready, inst, busy, done
  );
endinterface

// File: rtl/core_ctrl.sv
// Core run sequencer: loads Q and K vectors, preloads K into the array,
// executes the Q stream, then drains psum rows from the output FIFO into pmem.
//
//  state | meaning
//  IDLE  | waiting for start
//  WR_Q  | accept total_cycle Q vectors into qmem
//  WR_K  | accept col K vectors into kmem
//  LD_K  | stream col K vectors from kmem into the array
//  GAP   | one quiet cycle between load and execute
//  EXEC  | stream total_cycle Q vectors from qmem through the array
//  WR_P  | move total_cycle psum rows from the output FIFO into pmem
//  DONE  | one-cycle completion pulse
module core_ctrl #(
  parameter int col         = 8,
  parameter int total_cycle = 8
) (
  input  logic       clk,
  input  logic       reset,
  core_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WR_Q, WR_K, LD_K, GAP, EXEC, WR_P, DONE
  } state_t;

  localparam logic [3:0] COL_LAST = 4'(col - 1);
  localparam logic [3:0] TC_LAST  = 4'(total_cycle - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic       ofifo_rd, pmem_wr, kmem_wr, kmem_rd, qmem_wr, qmem_rd, execute, load;
  logic [3:0] pmem_add, qkmem_add;

  // State and phase counter; the counter doubles as the address of the current phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter update and instruction decode. The last beat of a phase
  // clears cnt and changes state on the same edge, so no phase ever wraps.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ofifo_rd     = 1'b0;
    pmem_wr      = 1'b0;
    kmem_wr      = 1'b0;
    kmem_rd      = 1'b0;
    qmem_wr      = 1'b0;
    qmem_rd      = 1'b0;
    execute      = 1'b0;
    load         = 1'b0;
    pmem_add     = 4'd0;
    qkmem_add    = 4'd0;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;

    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          state_nxt = WR_Q;
          cnt_nxt   = 4'd0;
        end
      end
      WR_Q: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          qmem_wr   = 1'b1;
          qkmem_add = cnt;
          if (cnt == TC_LAST) begin
            state_nxt = WR_K;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      WR_K: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          kmem_wr   = 1'b1;
          qkmem_add = cnt;
          if (cnt == COL_LAST) begin
            state_nxt = LD_K;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      LD_K: begin
        kmem_rd   = 1'b1;
        load      = 1'b1;
        qkmem_add = cnt;
        if (cnt == COL_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      GAP: begin
        state_nxt = EXEC;
        cnt_nxt   = 4'd0;
      end
      EXEC: begin
        qmem_rd   = 1'b1;
        execute   = 1'b1;
        qkmem_add = cnt;
        if (cnt == TC_LAST) begin
          state_nxt = WR_P;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WR_P: begin
        if (bus.ofifo_valid) begin
          ofifo_rd = 1'b1;
          pmem_wr  = 1'b1;
          pmem_add = cnt;
          if (cnt == TC_LAST) begin
            state_nxt = DONE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // pmem_rd (bit 6) is never used by this sequence.
  assign bus.inst = {2'b00, ofifo_rd, pmem_add, qkmem_add, pmem_wr, 1'b0,
                     kmem_wr, kmem_rd, qmem_wr, qmem_rd, execute, load};

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameter col, default 8: K vectors loaded per run; legal range 1..16.
REQ-002 SHALL have parameter total_cycle, default 8: Q vectors / psum rows per run; legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-006 SHALL have port in_valid  input  1  host drives a valid vector on the core mem_in bus this cycle.
REQ-007 SHALL have port in_ready  output  1  controller accepts a vector this cycle.
REQ-008 SHALL have port ofifo_valid  input  1  core output FIFO holds a psum row.
REQ-009 SHALL have port inst  output  19  core instruction word.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL use this inst field map: [18:17]=0, [16] ofifo_rd, [15:12] pmem_add, [11:8] qkmem_add, [7] pmem_wr, [6] pmem_rd (always 0), [5] kmem_wr, [4] kmem_rd, [3] qmem_wr, [2] qmem_rd, [1] execute, [0] load.
REQ-013 SHALL drive inst, in_ready, busy and done combinationally from the registered state, the 4-bit counter cnt, in_valid and ofifo_valid; no added register stage.
REQ-014 SHALL implement states IDLE, WR_Q, WR_K, LD_K, GAP, EXEC, WR_P, DONE; cnt SHALL be cleared on every state change.
REQ-015 In IDLE, start=1 SHALL move to WR_Q next cycle; start SHALL be ignored in every other state.
REQ-016 In WR_Q, in_ready=1; on in_valid: qmem_wr=1, qkmem_add=cnt, cnt+1; after total_cycle accepts, the next state SHALL be WR_K.
REQ-017 In WR_K, in_ready=1; on in_valid: kmem_wr=1, qkmem_add=cnt, cnt+1; after col accepts, the next state SHALL be LD_K.
REQ-018 In every state except WR_Q and WR_K, in_ready=0, and in_valid SHALL have no effect.
REQ-019 In LD_K, the controller SHALL hold kmem_rd=1, load=1 and qkmem_add=cnt every cycle; after col cycles, the next state SHALL be GAP.
REQ-020 GAP SHALL last exactly one cycle with all inst bits 0, then go to EXEC.
REQ-021 In EXEC, the controller SHALL hold qmem_rd=1, execute=1 and qkmem_add=cnt every cycle; after total_cycle cycles, the next state SHALL be WR_P.
REQ-022 In WR_P, when ofifo_valid=1: ofifo_rd=1, pmem_wr=1, pmem_add=cnt, cnt+1; when ofifo_valid=0, all inst bits SHALL be 0 and the state SHALL hold with no timeout.
REQ-023 After total_cycle writes in WR_P, the next state SHALL be DONE.
REQ-024 DONE SHALL assert done=1 for one cycle, drive inst=0, then return to IDLE.
REQ-025 A start asserted during DONE SHALL be ignored; a new run requires start in IDLE.
REQ-026 The final accept or write of a phase and the state transition SHALL occur on the same clock edge, with no dead cycle between phases except GAP.
REQ-027 Address fields SHALL never exceed their phase count minus 1; cnt SHALL not wrap inside a phase.
REQ-028 Unused address fields SHALL be driven to 0.

Reset
REQ-029 reset=0 SHALL immediately force state=IDLE, cnt=0, inst=0, in_ready=0, busy=0 and done=0, independent of clk.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-031 The first rising edge with reset=1 SHALL be a normal operating edge.

Verification
REQ-032 Default parameters, start at edge 0, in_valid and ofifo_valid held at 1 -> WR_Q over cycles 1-8, WR_K 9-16, LD_K 17-24, GAP 25, EXEC 26-33, WR_P 34-41, done=1 in cycle 42 only, busy=1 in cycles 1-42.
REQ-033 WR_Q with in_valid toggling 1,0,1,0 -> qmem_wr and the qkmem_add increment occur only on in_valid=1 cycles; WR_Q lasts 16 cycles; qkmem_add sequence is 0..7.
REQ-034 In WR_P, ofifo_valid=0 for 5 cycles, then 1 -> inst=0 for those 5 cycles, then 8 consecutive writes with pmem_add 0..7, then done.
REQ-035 Reset pulled low in EXEC with cnt=3 -> inst=0 and busy=0 asynchronously; no done pulse; a start after release repeats REQ-032 timing.
REQ-036 start held high through a whole run, and start pulsed during EXEC -> no effect mid-run; with start held high, a second run begins the cycle after DONE returns to IDLE.
REQ-037 col=1, total_cycle=16 -> LD_K lasts 1 cycle; EXEC lasts 16 cycles with qkmem_add 0..15; no cnt wrap.
